// File: rtl/cond_gate_if.sv
// Decode/execute handshake bundle for cond_gate.
// The gate uses the slave modport; the surrounding pipeline uses master.
interface cond_gate_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_cond;
    logic       in_sets_flags;
    logic       out_valid;
    logic       out_ready;
    logic       out_exec;
    logic       out_sets_flags;

    modport master (
        output in_valid, in_cond, in_sets_flags, out_ready,
        input  in_ready, out_valid, out_exec, out_sets_flags
    );

    modport slave (
        input  in_valid, in_cond, in_sets_flags, out_ready,
        output in_ready, out_valid, out_exec, out_sets_flags
    );
endinterface

// File: rtl/cond_gate.sv
// Holds one decoded instruction and evaluates its ARM condition against CPSR, stalling while flag writers are in flight.
// Optional FLAG_FWD_EN: resolve the stall one cycle early from the flag values being written.
module cond_gate #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    cond_gate_if.slave       bus,
    input  logic             N_flag,
    input  logic             Z_flag,
    input  logic             C_flag,
    input  logic             V_flag,
    input  logic             update_CPSR,
    input  logic             ignore_C_flag,
    input  logic             N_flag_temp,
    input  logic             Z_flag_temp,
    input  logic             C_flag_temp,
    input  logic             V_flag_temp,
    output logic [CNT_W-1:0] pending
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_VALID
    } state_t;

    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    function automatic logic f_cond_pass(input logic [3:0] c, input logic n, input logic z,
                                         input logic cf, input logic v);
        logic r;
        r = 1'b0;
        case (c)
            4'b0000: r = z;
            4'b0001: r = !z;
            4'b0010: r = cf;
            4'b0011: r = !cf;
            4'b0100: r = n;
            4'b0101: r = !n;
            4'b0110: r = v;
            4'b0111: r = !v;
            4'b1000: r = cf & !z;
            4'b1001: r = !cf | z;
            4'b1010: r = (n == v);
            4'b1011: r = (n != v);
            4'b1100: r = !z & (n == v);
            4'b1101: r = z | (n != v);
            4'b1110: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    state_t           r_state, w_state_nxt;
    logic             r_exec, w_exec_nxt;
    logic             r_sets, w_sets_nxt;
    logic [3:0]       r_cond, w_cond_nxt;
    logic [CNT_W-1:0] r_pend, w_pend_nxt;

    logic w_depart, w_issue, w_no_flags, w_hazard, w_slot, w_room, w_accept;
    logic w_pass_in, w_pass_held;

    assign w_depart   = (r_state == S_VALID) & bus.out_ready;
    assign w_issue    = w_depart & r_exec & r_sets;
    assign w_no_flags = (bus.in_cond[3:1] == 3'b111);
    assign w_hazard   = ((r_pend != '0) | w_issue) & !w_no_flags;
    assign w_slot     = (r_state == S_IDLE) | w_depart;
    assign w_room     = (r_pend != PEND_MAX) | !bus.in_sets_flags;
    assign w_accept   = bus.in_valid & bus.in_ready;

    assign w_pass_in   = f_cond_pass(bus.in_cond, N_flag, Z_flag, C_flag, V_flag);
    assign w_pass_held = f_cond_pass(r_cond, N_flag, Z_flag, C_flag, V_flag);

    assign bus.in_ready       = w_slot & w_room;
    assign bus.out_valid      = (r_state == S_VALID);
    assign bus.out_exec       = r_exec;
    assign bus.out_sets_flags = r_sets;
    assign pending            = r_pend;

`ifdef FLAG_FWD_EN
    logic w_fwd, w_pass_fwd;
    // The last outstanding write lands at this edge, so its data is already final on the temp bus.
    assign w_fwd      = (r_pend == CNT_W'(1)) & update_CPSR & !w_issue;
    assign w_pass_fwd = f_cond_pass(r_cond, N_flag_temp, Z_flag_temp,
                                    ignore_C_flag ? C_flag : C_flag_temp, V_flag_temp);
`else
    logic w_unused_fwd;
    assign w_unused_fwd = &{1'b0, ignore_C_flag, N_flag_temp, Z_flag_temp, C_flag_temp, V_flag_temp};
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_exec_nxt  = r_exec;
        w_sets_nxt  = r_sets;
        w_cond_nxt  = r_cond;
        case (r_state)
            S_IDLE, S_VALID: begin
                if (w_accept) begin
                    w_cond_nxt = bus.in_cond;
                    w_sets_nxt = bus.in_sets_flags;
                    if (w_hazard) begin
                        w_state_nxt = S_WAIT;
                        w_exec_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = S_VALID;
                        w_exec_nxt  = w_pass_in;
                    end
                end else if (w_depart) begin
                    w_state_nxt = S_IDLE;
                    w_exec_nxt  = 1'b0;
                end
            end
            S_WAIT: begin
                if (r_pend == '0) begin
                    w_state_nxt = S_VALID;
                    w_exec_nxt  = w_pass_held;
                end
`ifdef FLAG_FWD_EN
                else if (w_fwd) begin
                    w_state_nxt = S_VALID;
                    w_exec_nxt  = w_pass_fwd;
                end
`endif
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_pend_nxt = r_pend;
        case ({w_issue, update_CPSR})
            2'b10:   if (r_pend != PEND_MAX) w_pend_nxt = r_pend + CNT_W'(1);
            2'b01:   if (r_pend != '0)       w_pend_nxt = r_pend - CNT_W'(1);
            default: w_pend_nxt = r_pend;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_exec  <= 1'b0;
            r_sets  <= 1'b0;
            r_cond  <= '0;
            r_pend  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_exec  <= w_exec_nxt;
            r_sets  <= w_sets_nxt;
            r_cond  <= w_cond_nxt;
            r_pend  <= w_pend_nxt;
        end
    end

endmodule

// File: tb/tb_cond_gate.sv
// Self-checking bench for cond_gate: vector table through a scoreboard plus hand-built stall/counter sequences.
module tb_cond_gate;
    localparam int CNT_W = 2;

    logic clk = 1'b0;
    logic reset;
    logic N_flag, Z_flag, C_flag, V_flag;
    logic update_CPSR, ignore_C_flag;
    logic N_flag_temp, Z_flag_temp, C_flag_temp, V_flag_temp;
    logic [CNT_W-1:0] pending;

    cond_gate_if bus();

    cond_gate #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .N_flag       (N_flag),
        .Z_flag       (Z_flag),
        .C_flag       (C_flag),
        .V_flag       (V_flag),
        .update_CPSR  (update_CPSR),
        .ignore_C_flag(ignore_C_flag),
        .N_flag_temp  (N_flag_temp),
        .Z_flag_temp  (Z_flag_temp),
        .C_flag_temp  (C_flag_temp),
        .V_flag_temp  (V_flag_temp),
        .pending      (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic exec;
        logic sets;
    } exp_t;

    typedef struct {
        logic [3:0] cond;
        logic [3:0] nzcv;
        logic       exp;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference condition model: base test on cond[3:1], cond[0] inverts.
    function automatic logic model(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cc, v, b;
        {n, z, cc, v} = f;
        case (c[3:1])
            3'd0: b = z;
            3'd1: b = cc;
            3'd2: b = n;
            3'd3: b = v;
            3'd4: b = cc && !z;
            3'd5: b = (n == v);
            3'd6: b = !z && (n == v);
            default: b = 1'b1;
        endcase
        if (c[3:1] == 3'd7) return !c[0];
        return b ^ c[0];
    endfunction

    always @(negedge clk) begin
        if (reset === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_out: got out_valid=1, expected no pending instruction");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_exec", 32'(bus.out_exec), 32'(e.exec));
                check("out_sets_flags", 32'(bus.out_sets_flags), 32'(e.sets));
            end
        end
    end

    task automatic set_flags(input logic [3:0] f);
        {N_flag, Z_flag, C_flag, V_flag} = f;
    endtask

    task automatic send(input logic [3:0] c, input logic s, input logic e);
        exp_t x;
        bus.in_cond       = c;
        bus.in_sets_flags = s;
        bus.in_valid      = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                x.exec = e;
                x.sets = s;
                sb.push_back(x);
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                return;
            end
        end
        n_cmp++;
        n_err++;
        $display("FAIL send_timeout: got in_ready=0 for 50 cycles, expected acceptance (cond=%0h)", c);
        bus.in_valid = 1'b0;
    endtask

    task automatic upd(input logic [3:0] t, input logic ign);
        {N_flag_temp, Z_flag_temp, C_flag_temp, V_flag_temp} = t;
        ignore_C_flag = ign;
        update_CPSR   = 1'b1;
        @(posedge clk);
        #1;
        N_flag = t[3];
        Z_flag = t[2];
        V_flag = t[0];
        if (!ign) C_flag = t[1];
        update_CPSR   = 1'b0;
        ignore_C_flag = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50; i++) begin
            if (sb.size() == 0) return;
            @(posedge clk);
            #1;
        end
        n_cmp++;
        n_err++;
        $display("FAIL drain_timeout: got %0d outstanding, expected 0", sb.size());
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        vec_t v;

        // Hand-derived entries first, then the full model-driven sweep.
        vecs.push_back('{4'b1100, 4'b1001, 1'b1});
        vecs.push_back('{4'b1011, 4'b1000, 1'b1});
        vecs.push_back('{4'b1000, 4'b0010, 1'b1});
        vecs.push_back('{4'b1001, 4'b0110, 1'b1});
        vecs.push_back('{4'b1101, 4'b0000, 1'b0});
        vecs.push_back('{4'b1111, 4'b0100, 1'b0});
        for (int c = 0; c < 16; c++)
            for (int f = 0; f < 16; f++) begin
                v.cond = 4'(c);
                v.nzcv = 4'(f);
                v.exp  = model(4'(c), 4'(f));
                vecs.push_back(v);
            end

        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_cond = '0;
        bus.in_sets_flags = 1'b0;
        bus.out_ready = 1'b0;
        set_flags(4'b0000);
        update_CPSR = 1'b0;
        ignore_C_flag = 1'b0;
        {N_flag_temp, Z_flag_temp, C_flag_temp, V_flag_temp} = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_exec", 32'(bus.out_exec), 32'd0);
        check("rst_out_sets", 32'(bus.out_sets_flags), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        tick();

        // Z=1: EQ passes with one cycle latency, NE squashes.
        set_flags(4'b0100);
        bus.out_ready = 1'b1;
        send(4'b0000, 1'b0, 1'b1);
        @(negedge clk);
        check("latency1_out_valid", 32'(bus.out_valid), 32'd1);
        tick();
        send(4'b0001, 1'b0, 1'b0);
        drain();

        t0 = cyc;
        for (int i = 0; i < 8; i++) send(4'b1110, 1'b0, 1'b1);
        check("b2b_cycles", 32'(cyc - t0), 32'd8);
        drain();

        foreach (vecs[i]) begin
            set_flags(vecs[i].nzcv);
            send(vecs[i].cond, 1'b0, vecs[i].exp);
        end
        drain();

        // MOVS then EQ: stall until the flag write lands.
        set_flags(4'b0100);
        send(4'b1110, 1'b1, 1'b1);
        send(4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        check("haz_pending", 32'(pending), 32'd1);
        check("haz_out_valid", 32'(bus.out_valid), 32'd0);
        tick();
        @(negedge clk);
        check("haz_hold", 32'(bus.out_valid), 32'd0);
        tick();
        upd(4'b0000, 1'b0);
        @(negedge clk);
        check("haz_pend_clear", 32'(pending), 32'd0);
`ifdef FLAG_FWD_EN
        check("haz_fwd_exit", 32'(bus.out_valid), 32'd1);
`else
        check("haz_no_early", 32'(bus.out_valid), 32'd0);
        tick();
        @(negedge clk);
        check("haz_exit", 32'(bus.out_valid), 32'd1);
`endif
        tick();
        drain();

        // Write that leaves C alone: CS must still see C=1.
        set_flags(4'b0010);
        send(4'b1110, 1'b1, 1'b1);
        send(4'b0010, 1'b0, 1'b1);
        upd(4'b0000, 1'b1);
        drain();
        repeat (3) tick();
        check("ignc_pending", 32'(pending), 32'd0);

        // Three writers outstanding saturate the counter for further setters only.
        set_flags(4'b0000);
        for (int i = 0; i < 3; i++) send(4'b1110, 1'b1, 1'b1);
        tick();
        bus.in_cond = 4'b1110;
        bus.in_sets_flags = 1'b1;
        @(negedge clk);
        check("full_pending", 32'(pending), 32'd3);
        check("full_setter_ready", 32'(bus.in_ready), 32'd0);
        bus.in_sets_flags = 1'b0;
        #1;
        check("full_plain_ready", 32'(bus.in_ready), 32'd1);
        tick();
        upd(4'b0000, 1'b0);
        check("full_dec2", 32'(pending), 32'd2);
        upd(4'b0000, 1'b0);
        check("full_dec1", 32'(pending), 32'd1);
        upd(4'b0000, 1'b0);
        check("full_dec0", 32'(pending), 32'd0);

        // Issue and update on the same edge cancel; update at zero floors.
        send(4'b1110, 1'b1, 1'b1);
        send(4'b1110, 1'b1, 1'b1);
        upd(4'b0000, 1'b0);
        check("pend_both", 32'(pending), 32'd1);
        upd(4'b0000, 1'b0);
        check("pend_dec", 32'(pending), 32'd0);
        upd(4'b0000, 1'b0);
        check("pend_floor", 32'(pending), 32'd0);
        drain();

        // Reset while stalled drops the held instruction.
        send(4'b1110, 1'b1, 1'b1);
        send(4'b0000, 1'b0, 1'b1);
        @(negedge clk);
        check("rst_wait_pending", 32'(pending), 32'd1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        check("rstw_out_valid", 32'(bus.out_valid), 32'd0);
        check("rstw_pending", 32'(pending), 32'd0);
        check("rstw_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (3) tick();
        check("rstw_quiet", 32'(bus.out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
